// File: rtl/video_timing_pkg.sv
// Shared timing record and the PAL/NTSC mode table for the raster timing generator.
package video_timing_pkg;

    localparam int TW = 16;

    typedef struct packed {
        logic [TW-1:0] hTotal;
        logic [TW-1:0] hBlankStart;
        logic [TW-1:0] hSyncStart;
        logic [TW-1:0] hSyncEnd;
        logic [TW-1:0] vTotal;
        logic [TW-1:0] vBlankStart;
        logic [TW-1:0] vSyncStart;
        logic [TW-1:0] vSyncEnd;
    } timing_t;

    localparam timing_t PAL_TIMING = '{
        hTotal: 16'd448, hBlankStart: 16'd352, hSyncStart: 16'd376, hSyncEnd: 16'd407,
        vTotal: 16'd312, vBlankStart: 16'd304, vSyncStart: 16'd304, vSyncEnd: 16'd307
    };

    localparam timing_t NTSC_TIMING = '{
        hTotal: 16'd445, hBlankStart: 16'd352, hSyncStart: 16'd376, hSyncEnd: 16'd407,
        vTotal: 16'd262, vBlankStart: 16'd254, vSyncStart: 16'd254, vSyncEnd: 16'd257
    };

endpackage

// File: rtl/video_timing_gen_if.sv
// Pixel strobe, mode request and the registered raster outputs of video_timing_gen.
interface video_timing_gen_if #(
    parameter int CW = 9,
    parameter int MW = 1
);
    logic          ce;
    logic [MW-1:0] mode_in;
    logic [MW-1:0] mode_cur;
    logic [CW-1:0] hc;
    logic [CW-1:0] vc;
    logic          hsync_n;
    logic          vsync_n;
    logic          csync_n;
    logic          hblank;
    logic          vblank;
    logic          blank;
    logic          line_start;
    logic          frame_start;
    logic          field;

    modport master (
        output ce, mode_in,
        input  mode_cur, hc, vc, hsync_n, vsync_n, csync_n,
               hblank, vblank, blank, line_start, frame_start, field
    );

    modport slave (
        input  ce, mode_in,
        output mode_cur, hc, vc, hsync_n, vsync_n, csync_n,
               hblank, vblank, blank, line_start, frame_start, field
    );
endinterface

// File: rtl/timing_window_decode.sv
// Unsigned inclusive window compare: inside_o is high while start_i <= count_i <= end_i.
module timing_window_decode
    import video_timing_pkg::*;
#(
    parameter int W = TW
) (
    input  logic [W-1:0] count_i,
    input  logic [W-1:0] start_i,
    input  logic [W-1:0] end_i,
    output logic         inside_o
);
    assign inside_o = (count_i >= start_i) && (count_i <= end_i);
endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: h/v counters driven by a per-frame mode table, with
// sync/blank/strobe outputs registered one pixel stage behind, aligned with hc/vc.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int      CW     = 9,
    parameter int      NMODES = 2,
    parameter int      MW     = 1,
    parameter timing_t MODE0  = PAL_TIMING,
    parameter timing_t MODE1  = NTSC_TIMING
) (
    input  logic              clk,
    input  logic              rst_n,
    video_timing_gen_if.slave vid
);

    localparam logic [CW-1:0] ONE = CW'(1);

    timing_t       cur;
    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic [MW-1:0] mode_q, mode_d;
    logic          fieldInt_q, fieldInt_d;
    logic [TW-1:0] hWide, vWide, hLast, vLast;
    logic          hBlankWin, vBlankWin, hSyncWin, vSyncWin;
    logic          modeValid;

    logic [CW-1:0] hc_q, vc_q;
    logic [MW-1:0] modeCur_q;
    logic          hsyncN_q, vsyncN_q, csyncN_q;
    logic          hblank_q, vblank_q, blank_q;
    logic          lineStart_q, frameStart_q, field_q;

    // Mode 0 selects the first table entry; every other accepted mode uses the second.
    assign cur       = (mode_q == '0) ? MODE0 : MODE1;
    assign hWide     = TW'(h_q);
    assign vWide     = TW'(v_q);
    assign hLast     = cur.hTotal - TW'(1);
    assign vLast     = cur.vTotal - TW'(1);
    assign modeValid = (int'(vid.mode_in) < NMODES);

    always_comb begin
        h_d        = h_q;
        v_d        = v_q;
        mode_d     = mode_q;
        fieldInt_d = fieldInt_q;
        if (vid.ce) begin
            if (hWide == hLast) begin
                h_d = '0;
                if (vWide == vLast) begin
                    v_d        = '0;
                    fieldInt_d = ~fieldInt_q;
                    if (modeValid) begin
                        mode_d = vid.mode_in;
                    end
                end else begin
                    v_d = v_q + ONE;
                end
            end else begin
                h_d = h_q + ONE;
            end
        end
    end

    timing_window_decode #(.W(TW)) uHBlank (
        .count_i(hWide), .start_i(cur.hBlankStart), .end_i(hLast), .inside_o(hBlankWin)
    );
    timing_window_decode #(.W(TW)) uHSync (
        .count_i(hWide), .start_i(cur.hSyncStart), .end_i(cur.hSyncEnd), .inside_o(hSyncWin)
    );
    timing_window_decode #(.W(TW)) uVBlank (
        .count_i(vWide), .start_i(cur.vBlankStart), .end_i(vLast), .inside_o(vBlankWin)
    );
    timing_window_decode #(.W(TW)) uVSync (
        .count_i(vWide), .start_i(cur.vSyncStart), .end_i(cur.vSyncEnd), .inside_o(vSyncWin)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q        <= '0;
            v_q        <= '0;
            mode_q     <= '0;
            fieldInt_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            mode_q     <= mode_d;
            fieldInt_q <= fieldInt_d;
        end
    end

    // Output stage samples the decode of the current counters, so hc/vc match the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q         <= '0;
            vc_q         <= '0;
            modeCur_q    <= '0;
            hsyncN_q     <= 1'b1;
            vsyncN_q     <= 1'b1;
            csyncN_q     <= 1'b1;
            hblank_q     <= 1'b0;
            vblank_q     <= 1'b0;
            blank_q      <= 1'b0;
            lineStart_q  <= 1'b0;
            frameStart_q <= 1'b0;
            field_q      <= 1'b0;
        end else if (vid.ce) begin
            hc_q         <= h_q;
            vc_q         <= v_q;
            modeCur_q    <= mode_q;
            hsyncN_q     <= ~hSyncWin;
            vsyncN_q     <= ~vSyncWin;
            csyncN_q     <= ~(hSyncWin | vSyncWin);
            hblank_q     <= hBlankWin;
            vblank_q     <= vBlankWin;
            blank_q      <= hBlankWin | vBlankWin;
            lineStart_q  <= (h_q == '0);
            frameStart_q <= (h_q == '0) && (v_q == '0);
            field_q      <= fieldInt_q;
        end
    end

    assign vid.hc          = hc_q;
    assign vid.vc          = vc_q;
    assign vid.mode_cur    = modeCur_q;
    assign vid.hsync_n     = hsyncN_q;
    assign vid.vsync_n     = vsyncN_q;
    assign vid.csync_n     = csyncN_q;
    assign vid.hblank      = hblank_q;
    assign vid.vblank      = vblank_q;
    assign vid.blank       = blank_q;
    assign vid.line_start  = lineStart_q;
    assign vid.frame_start = frameStart_q;
    assign vid.field       = field_q;

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter CW, default 9, width of horizontal/vertical counters.
REQ-002 SHALL have parameter NMODES, default 2, number of timing-table entries.
REQ-003 SHALL have parameter MW, default 1, mode select width; NMODES <= 2**MW.
REQ-004 SHALL have port clk, input, 1, pixel-domain clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port ce, input, 1, pixel strobe; counters advance only when 1.
REQ-007 SHALL have port mode_in, input, MW, requested timing mode (0 PAL, 1 NTSC).
REQ-008 SHALL have port mode_cur, output, MW, mode used by current frame.
REQ-009 SHALL have ports hc, vc, outputs, CW each, pixel and line position.
REQ-010 SHALL have ports hsync_n, vsync_n, csync_n, outputs, 1 each, active-low syncs.
REQ-011 SHALL have ports hblank, vblank, blank, outputs, 1 each, active-high blanking.
REQ-012 SHALL have ports line_start, frame_start, outputs, 1 each, single-ce pulses.
REQ-013 SHALL have port field, output, 1, toggles every frame.

Function
REQ-014 Internal h counter SHALL count 0..H_TOTAL-1 of mode_cur on each ce, then wrap to 0.
REQ-015 Internal v counter SHALL increment on each h wrap, and wrap to 0 after V_TOTAL-1.
REQ-016 ce=0 SHALL hold all counters and registered outputs unchanged.
REQ-017 mode_in SHALL be sampled only on the ce cycle where h=H_TOTAL-1 and v=V_TOTAL-1; the new mode governs the following frame.
REQ-018 mode_in >= NMODES at the sample point SHALL be ignored; mode_cur is retained.
REQ-019 mode_in changes at any other time SHALL have no effect.
REQ-020 hblank SHALL be 1 for h in [HBS, H_TOTAL-1]; vblank SHALL be 1 for v in [VBS, V_TOTAL-1].
REQ-021 hsync_n SHALL be 0 for h in [HSS, HSE]; vsync_n SHALL be 0 for v in [VSS, VSE].
REQ-022 blank SHALL equal hblank OR vblank.
REQ-023 csync_n SHALL equal hsync_n AND vsync_n.
REQ-024 line_start SHALL be 1 exactly when h=0; frame_start SHALL be 1 exactly when h=0 and v=0.
REQ-025 field SHALL toggle at every v wrap.
REQ-026 All outputs SHALL be registered, one ce-stage after the internal counters.
REQ-027 hc, vc SHALL be delayed by the same stage so that all outputs are mutually aligned.
REQ-028 Counter arithmetic SHALL be CW-bit unsigned; table values SHALL fit CW bits, and the decode SHALL use unsigned compares only.

Reset
REQ-029 On rst_n=0, h, v and hc, vc SHALL be 0.
REQ-030 On rst_n=0, mode_cur and field SHALL be 0.
REQ-031 On rst_n=0, hsync_n, vsync_n and csync_n SHALL be 1.
REQ-032 On rst_n=0, hblank, vblank, blank, line_start and frame_start SHALL be 0.
REQ-033 Reset mid-frame SHALL abort the frame; the first ce after release SHALL start the frame in mode 0 at h=0, v=0.

Structure
REQ-034 The timing record (H_TOTAL, HBS, HSS, HSE, V_TOTAL, VBS, VSS, VSE) and the mode table SHALL live in shared package video_timing_pkg.
REQ-035 Mode 0 SHALL be 448, 352, 376, 407, 312, 304, 304, 307.
REQ-036 Mode 1 SHALL be 445, 352, 376, 407, 262, 254, 254, 257.
REQ-037 One sub-module, timing_window_decode (counter versus start/end comparator), SHALL be instantiated once per h window and once per v window.

Verification
REQ-038 Reset, ce=1 constant, mode_in=0 -> frame_start period 448*312 cycles; hsync_n low 32 ce per line at hc 376..407.
REQ-039 mode_in=1 set mid-frame -> mode_cur changes to 1 only after hc=447, vc=311; next frame has 445*262 cycles, vsync_n low at vc 254..257.
REQ-040 ce toggled 1/0 alternately -> hc advances every second clk; all outputs stable while ce=0.
REQ-041 mode_in=3 with MW=2, NMODES=2 at frame end -> mode_cur unchanged, timing unchanged.
REQ-042 rst_n asserted at hc=200, vc=100 -> outputs at reset values immediately; after release the count restarts at 0,0 with mode 0.
REQ-043 Over two frames -> field 0 then 1; csync_n equals hsync_n AND vsync_n and blank equals hblank OR vblank on every cycle.
